// File: rtl/pc_trace_pkg.sv
// Shared state encoding for the PC trace monitor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// The state values are visible on the o_state port, so the encoding is
// fixed: IDLE=0, RUN=1, HALTED=2, TIMEOUT=3.
package pc_trace_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_HALTED  = 2'd2;
    localparam logic [1:0] ST_TIMEOUT = 2'd3;

    // The S_ prefix keeps S_TIMEOUT distinct from the TIMEOUT parameter of the top.
    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_RUN     = ST_RUN,
        S_HALTED  = ST_HALTED,
        S_TIMEOUT = ST_TIMEOUT
    } state_t;

endpackage

// File: rtl/pc_trace_buf.sv
// Circular buffer of recently retired PCs, read back by age (0 = newest).
// Latency: push visible to reads one edge later; read data registered, 1 cycle.
// Backpressure: none; pushes always accepted, oldest entry overwritten when full.
//
// Ports: i_clk/i_rst (sync active-high), i_clr (empty the buffer),
//        i_push/i_pc (write one entry), i_rd_idx -> o_rd_pc (relative read).
module pc_trace_buf #(
    parameter int PC_W  = 32,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_clr,
    input  logic                     i_push,
    input  logic [PC_W-1:0]          i_pc,
    input  logic [$clog2(DEPTH)-1:0] i_rd_idx,
    output logic [PC_W-1:0]          o_rd_pc
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W:0] CNT_MAX = (IDX_W + 1)'(DEPTH);

    logic [PC_W-1:0]  mem [DEPTH];
    logic [IDX_W-1:0] wr_ptr;
    logic [IDX_W:0]   vld_cnt;
    logic [IDX_W-1:0] rd_addr;
    logic [PC_W-1:0]  rd_pc;

    // wr_ptr points at the next free slot, so the newest entry is wr_ptr-1.
    // DEPTH is a power of two, so the subtraction wraps naturally.
    assign rd_addr = wr_ptr - IDX_W'(1) - i_rd_idx;

    // Storage needs no reset: entries beyond vld_cnt are never returned.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            mem[wr_ptr] <= i_pc;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            wr_ptr  <= '0;
            vld_cnt <= '0;
        end else if (i_push) begin
            wr_ptr <= wr_ptr + IDX_W'(1);
            if (vld_cnt != CNT_MAX) begin
                vld_cnt <= vld_cnt + 1'b1;
            end
        end
    end

    // Uses pre-edge pointer and count, so a same-edge push is not yet seen.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_pc <= '0;
        end else if ({1'b0, i_rd_idx} < vld_cnt) begin
            rd_pc <= mem[rd_addr];
        end else begin
            rd_pc <= '0;
        end
    end

    assign o_rd_pc = rd_pc;

endmodule

// File: rtl/pc_trace_monitor.sv
// Retirement monitor: counts instructions/cycles/stalls, detects self-loop halt or watchdog timeout.
// Latency: all outputs registered, event at edge N visible after edge N; trace read 1 cycle.
// Backpressure: none; observes the core passively every cycle.
//
// Ports: i_clk, i_rst (sync active-high), i_pc_debug/i_insn_vld (retirement),
//        i_start (arm/re-arm), i_rd_idx -> o_rd_pc (trace read, 0 = newest),
//        o_insn_cnt/o_cyc_cnt/o_stall_cnt, o_state, o_done, o_pass.
// Build option: define PC_TRACE_EN to include the trace buffer; otherwise o_rd_pc is 0.
module pc_trace_monitor
    import pc_trace_pkg::*;
#(
    parameter int PC_W        = 32,
    parameter int CNT_W       = 32,
    parameter int DEPTH       = 16,
    parameter int HALT_CYCLES = 8,
    parameter int TIMEOUT     = 5000
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [PC_W-1:0]          i_pc_debug,
    input  logic                     i_insn_vld,
    input  logic                     i_start,
    input  logic [$clog2(DEPTH)-1:0] i_rd_idx,
    output logic [PC_W-1:0]          o_rd_pc,
    output logic [CNT_W-1:0]         o_insn_cnt,
    output logic [CNT_W-1:0]         o_cyc_cnt,
    output logic [CNT_W-1:0]         o_stall_cnt,
    output logic [1:0]               o_state,
    output logic                     o_done,
    output logic                     o_pass
);

    localparam int REP_W = $clog2(HALT_CYCLES + 1);
    localparam logic [REP_W-1:0] HALT_VAL = REP_W'(HALT_CYCLES);
    localparam logic [CNT_W-1:0] TMO_VAL  = CNT_W'(TIMEOUT);

    state_t           state;
    logic [CNT_W-1:0] insn_cnt;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [PC_W-1:0]  last_pc;
    logic [REP_W-1:0] rep_cnt;
    logic             done_q;
    logic             pass_q;

    logic             in_run;
    logic             arm;
    logic             push;
    logic [REP_W-1:0] rep_nxt;
    logic [CNT_W-1:0] cyc_nxt;
    logic             halt_hit;
    logic             tmo_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign in_run = (state == S_RUN);
    // i_start only matters outside RUN; arm marks every entry into RUN.
    assign arm    = i_start && !in_run;
    assign push   = in_run && i_insn_vld;

    // rep_cnt stays below HALT_CYCLES while in RUN (reaching it leaves RUN),
    // so the increment cannot overflow REP_W.
    always_comb begin
        rep_nxt = REP_W'(1);
        if (i_pc_debug == last_pc) begin
            rep_nxt = rep_cnt + 1'b1;
        end
    end

    assign cyc_nxt  = sat_inc(cyc_cnt);
    // Both compare against post-edge values so the flag lands with the count.
    assign halt_hit = push && (rep_nxt == HALT_VAL);
    assign tmo_hit  = (TIMEOUT != 0) && (cyc_nxt == TMO_VAL);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_IDLE;
            insn_cnt  <= '0;
            cyc_cnt   <= '0;
            stall_cnt <= '0;
            last_pc   <= '0;
            rep_cnt   <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    cyc_cnt <= cyc_nxt;
                    if (i_insn_vld) begin
                        insn_cnt <= sat_inc(insn_cnt);
                        rep_cnt  <= rep_nxt;
                        last_pc  <= i_pc_debug;
                    end else begin
                        stall_cnt <= sat_inc(stall_cnt);
                    end
                    // Halt takes priority when both fire on the same edge.
                    if (halt_hit) begin
                        state  <= S_HALTED;
                        done_q <= 1'b1;
                        pass_q <= 1'b1;
                    end else if (tmo_hit) begin
                        state  <= S_TIMEOUT;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    // IDLE, HALTED, TIMEOUT: everything frozen until armed.
                    if (arm) begin
                        state     <= S_RUN;
                        insn_cnt  <= '0;
                        cyc_cnt   <= '0;
                        stall_cnt <= '0;
                        rep_cnt   <= '0;
                        done_q    <= 1'b0;
                        pass_q    <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign o_insn_cnt  = insn_cnt;
    assign o_cyc_cnt   = cyc_cnt;
    assign o_stall_cnt = stall_cnt;
    assign o_state     = state;
    assign o_done      = done_q;
    assign o_pass      = pass_q;

`ifdef PC_TRACE_EN
    pc_trace_buf #(
        .PC_W  (PC_W),
        .DEPTH (DEPTH)
    ) u_trace (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (arm),
        .i_push   (push),
        .i_pc     (i_pc_debug),
        .i_rd_idx (i_rd_idx),
        .o_rd_pc  (o_rd_pc)
    );
`else
    logic unused_rd_idx;
    assign unused_rd_idx = ^i_rd_idx;
    assign o_rd_pc       = '0;
`endif

endmodule

// File: tb/tb_pc_trace_monitor.sv
// Self-checking bench for pc_trace_monitor against a queue-based reference model.
// Latency: inputs driven on negedge, outputs compared 1 time unit after posedge.
// Backpressure: n/a.
module tb_pc_trace_monitor;

    localparam int PC_W        = 32;
    localparam int CNT_W       = 32;
    localparam int DEPTH       = 16;
    localparam int HALT_CYCLES = 8;
    localparam int TIMEOUT     = 50;
`ifdef PC_TRACE_EN
    localparam bit TRACE_EN = 1'b1;
`else
    localparam bit TRACE_EN = 1'b0;
`endif

    localparam int M_IDLE = 0, M_RUN = 1, M_HALTED = 2, M_TIMEOUT = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [PC_W-1:0]  pc_debug = '0;
    logic             insn_vld = 1'b0;
    logic             start = 1'b0;
    logic [3:0]       rd_idx = '0;
    logic [PC_W-1:0]  rd_pc;
    logic [CNT_W-1:0] insn_cnt, cyc_cnt, stall_cnt;
    logic [1:0]       state;
    logic             done, pass;

    always #5 clk = ~clk;

    pc_trace_monitor #(
        .PC_W        (PC_W),
        .CNT_W       (CNT_W),
        .DEPTH       (DEPTH),
        .HALT_CYCLES (HALT_CYCLES),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_pc_debug  (pc_debug),
        .i_insn_vld  (insn_vld),
        .i_start     (start),
        .i_rd_idx    (rd_idx),
        .o_rd_pc     (rd_pc),
        .o_insn_cnt  (insn_cnt),
        .o_cyc_cnt   (cyc_cnt),
        .o_stall_cnt (stall_cnt),
        .o_state     (state),
        .o_done      (done),
        .o_pass      (pass)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain integers and a newest-first queue of PCs.
    int          m_state = M_IDLE;
    int          m_insn = 0, m_cyc = 0, m_stall = 0, m_rep = 0;
    bit [31:0]   m_last = 0;
    bit [31:0]   m_trace[$];
    bit [31:0]   m_rd = 0;

    task automatic model_edge(input bit r, input bit s, input bit v, input bit [31:0] p, input int idx);
        if (r) begin
            m_state = M_IDLE; m_insn = 0; m_cyc = 0; m_stall = 0; m_rep = 0; m_last = 0;
            m_trace.delete();
            m_rd = 0;
            return;
        end
        m_rd = (TRACE_EN && idx < m_trace.size()) ? m_trace[idx] : 32'd0;
        if (m_state != M_RUN) begin
            if (s) begin
                m_state = M_RUN; m_insn = 0; m_cyc = 0; m_stall = 0; m_rep = 0;
                m_trace.delete();
            end
        end else begin
            m_cyc++;
            if (v) begin
                m_insn++;
                m_trace.push_front(p);
                if (m_trace.size() > DEPTH) void'(m_trace.pop_back());
                m_rep  = (p == m_last) ? m_rep + 1 : 1;
                m_last = p;
            end else begin
                m_stall++;
            end
            if (m_rep == HALT_CYCLES) m_state = M_HALTED;
            else if (TIMEOUT != 0 && m_cyc == TIMEOUT) m_state = M_TIMEOUT;
        end
    endtask

    task automatic step(input bit r, input bit s, input bit v, input bit [31:0] p, input int idx);
        @(negedge clk);
        rst = r; start = s; insn_vld = v; pc_debug = p; rd_idx = 4'(idx);
        @(posedge clk);
        model_edge(r, s, v, p, idx);
        #1;
        check("state", 64'(state), 64'(m_state));
        check("done",  64'(done),  64'(m_state == M_HALTED || m_state == M_TIMEOUT));
        check("pass",  64'(pass),  64'(m_state == M_HALTED));
        check("insn",  64'(insn_cnt),  64'(m_insn));
        check("cyc",   64'(cyc_cnt),   64'(m_cyc));
        check("stall", 64'(stall_cnt), 64'(m_stall));
        check("rd_pc", 64'(rd_pc), 64'(m_rd));
    endtask

    function automatic logic [63:0] tr(input logic [31:0] v);
        return TRACE_EN ? 64'(v) : 64'd0;
    endfunction

    initial begin
        bit [31:0] prev_pc;
        int k;

        // Reset state
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("rst_state", 64'(state), 0);
        check("rst_cnt", 64'(insn_cnt | cyc_cnt | stall_cnt), 0);
        check("rst_flags", 64'({done, pass}), 0);

        // Halt detection; retirement in the start cycle is ignored
        step(0, 1, 1, 32'h100, 0);
        check("start_ign", 64'(insn_cnt), 0);
        step(0, 0, 1, 32'h0, 0);
        step(0, 0, 1, 32'h4, 0);
        step(0, 0, 1, 32'h8, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 32'hC, 0);
        check("halt_state", 64'(state), 2);
        check("halt_insn", 64'(insn_cnt), 11);
        check("halt_pass", 64'(pass), 1);
        check("halt_done", 64'(done), 1);
        step(0, 0, 0, 0, 0);
        check("halt_rd0", 64'(rd_pc), tr(32'hC));
        step(0, 0, 0, 0, 8);
        check("halt_rd8", 64'(rd_pc), tr(32'h8));
        step(0, 0, 0, 0, 11);
        check("halt_rd11", 64'(rd_pc), 0);
        check("halt_frozen", 64'(cyc_cnt), 11);

        // Invalid cycles keep the repeat run alive
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 32'hC, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 32'hC, 0);
        step(0, 0, 1, 32'hC, 0);
        check("gap_halt", 64'(state), 2);
        check("gap_stall", 64'(stall_cnt), 3);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 32'hC, 0);
        step(0, 0, 1, 32'h10, 0);
        check("nohalt", 64'(state), 1);

        // Watchdog: non-repeating PCs until cycle 50
        for (int j = 0; j < 42; j++) begin
            step(0, 0, (j % 3) != 0, 32'h1000 + 4 * j, 0);
            if (j == 40) check("wd_prerun", 64'(state), 1);
        end
        check("wd_state", 64'(state), 3);
        check("wd_cyc", 64'(cyc_cnt), 50);
        check("wd_flags", 64'({done, pass}), 64'b10);
        step(0, 1, 0, 0, 0);
        check("rearm_state", 64'(state), 1);
        check("rearm_cnt", 64'(insn_cnt | cyc_cnt | stall_cnt), 0);

        // Stalls: alternate valid/invalid for 20 cycles
        for (int i = 0; i < 20; i++) step(0, 0, (i % 2) == 0, 32'h3000 + 4 * i, 0);
        check("st_insn", 64'(insn_cnt), 10);
        check("st_stall", 64'(stall_cnt), 10);
        check("st_cyc", 64'(cyc_cnt), 20);

        // Trace wrap: 20 pushes into 16 entries
        for (int i = 0; i < 10; i++) step(0, 0, 1, 32'h4000 + 4 * i, 0);
        step(0, 0, 0, 0, 0);
        check("wrap_rd0", 64'(rd_pc), tr(32'h4024));
        step(0, 0, 0, 0, 15);
        check("wrap_rd15", 64'(rd_pc), tr(32'h3020));
        for (int i = 0; i < 16; i++) step(0, 0, 0, 0, i);
        k = 0;
        while (state != 2'd3 && k < 60) begin
            step(0, 0, 0, 0, 0);
            k++;
        end
        check("wd_wait", 64'(state), 3);

        // Re-arm clears the trace count
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 32'h5000, 0);
        step(0, 0, 1, 32'h5004, 0);
        step(0, 0, 0, 0, 3);
        check("clr_rd3", 64'(rd_pc), 0);
        step(0, 0, 0, 0, 1);
        check("clr_rd1", 64'(rd_pc), tr(32'h5000));

        // Reset mid-RUN beats start
        step(0, 0, 1, 32'h6000, 0);
        step(1, 1, 1, 32'h6004, 0);
        check("mrst_state", 64'(state), 0);
        check("mrst_all", 64'({insn_cnt, cyc_cnt} | 64'(stall_cnt) | 64'(rd_pc) | 64'({done, pass})), 0);

        // Randomized traffic, biased toward repeated PCs
        prev_pc = 0;
        for (int i = 0; i < 600; i++) begin
            bit r, s, v;
            bit [31:0] p;
            r = ($urandom_range(0, 149) == 0);
            s = ($urandom_range(0, 11) == 0);
            v = ($urandom_range(0, 3) != 0);
            p = ($urandom_range(0, 3) != 0) ? prev_pc : 32'($urandom_range(0, 5)) << 2;
            prev_pc = p;
            step(r, s, v, p, $urandom_range(0, 15));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
